// File: rtl/sccb_init_seq.sv
// rtl/sccb_init_seq.sv - table-driven SCCB register-init sequencer with optional read-back verify
module sccb_init_seq #(
    parameter logic [7:0] CHIP_ADDR  = 8'h42,
    parameter int         MAX_CMDS   = 64,
    parameter int         CYC_PER_MS = 25000,
    parameter bit         VERIFY     = 1'b1,
    parameter int         MAX_TRIES  = 3,
    parameter logic [7:0] DELAY_TAG  = 8'hF0,
    parameter logic [7:0] END_TAG    = 8'hFF,
    localparam int        AW         = $clog2(MAX_CMDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    output logic [AW-1:0] o_rom_addr,
    input  logic [15:0]   i_rom_data,
    output logic          o_sccb_start,
    output logic          o_sccb_rw,
    output logic [7:0]    o_sccb_addr,
    output logic [7:0]    o_sccb_subaddr,
    output logic [7:0]    o_sccb_wdata,
    input  logic [7:0]    i_sccb_rdata,
    input  logic          i_sccb_done,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [AW-1:0] o_err_index
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int PW = $clog2(CYC_PER_MS + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_WWAIT, S_READ,
        S_RWAIT, S_CHECK, S_DELAY, S_NEXT, S_DONE, S_FAIL
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_index;
    logic [TW-1:0] r_try;
    logic [PW-1:0] r_pre;
    logic [7:0]    r_ms;
    logic [7:0]    r_sub;
    logic [7:0]    r_value;
    logic [7:0]    r_rdata;

    // COM7 with the soft-reset bit self-clears, so reading it back can never match
    wire w_verifiable = VERIFY && !(r_sub == 8'h12 && r_value[7]);
    wire w_last       = (r_index == AW'(MAX_CMDS - 1));
    wire w_retry      = (r_try + 1'b1) < TW'(MAX_TRIES);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_index        <= '0;
            r_try          <= '0;
            r_pre          <= '0;
            r_ms           <= '0;
            r_sub          <= '0;
            r_value        <= '0;
            r_rdata        <= '0;
            o_rom_addr     <= '0;
            o_sccb_start   <= 1'b0;
            o_sccb_rw      <= 1'b0;
            o_sccb_addr    <= '0;
            o_sccb_subaddr <= '0;
            o_sccb_wdata   <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_err_index    <= '0;
        end else begin
            o_sccb_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (i_start) begin
                        o_done      <= 1'b0;
                        o_error     <= 1'b0;
                        o_err_index <= '0;
                        r_index     <= '0;
                        r_try       <= '0;
                        o_rom_addr  <= '0;
                        o_busy      <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                // rom_addr was already updated on entry, so the ROM output is valid in DECODE
                S_FETCH: begin
                    o_rom_addr <= r_index;
                    r_state    <= S_DECODE;
                end
                S_DECODE: begin
                    r_sub   <= i_rom_data[15:8];
                    r_value <= i_rom_data[7:0];
                    if (i_rom_data[15:8] == END_TAG) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (i_rom_data[15:8] == DELAY_TAG) begin
                        r_ms    <= i_rom_data[7:0];
                        r_pre   <= '0;
                        r_state <= (i_rom_data[7:0] == 8'h00) ? S_NEXT : S_DELAY;
                    end else begin
                        o_sccb_start   <= 1'b1;
                        o_sccb_rw      <= 1'b0;
                        o_sccb_addr    <= CHIP_ADDR & 8'hFE;
                        o_sccb_subaddr <= i_rom_data[15:8];
                        o_sccb_wdata   <= i_rom_data[7:0];
                        r_state        <= S_WRITE;
                    end
                end
                S_WRITE: r_state <= S_WWAIT;
                S_WWAIT: begin
                    if (i_sccb_done) begin
                        if (w_verifiable) begin
                            o_sccb_start <= 1'b1;
                            o_sccb_rw    <= 1'b1;
                            o_sccb_addr  <= CHIP_ADDR | 8'h01;
                            r_state      <= S_READ;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_READ: r_state <= S_RWAIT;
                S_RWAIT: begin
                    if (i_sccb_done) begin
                        r_rdata <= i_sccb_rdata;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_rdata == r_value) begin
                        r_try   <= '0;
                        r_state <= S_NEXT;
                    end else if (w_retry) begin
                        r_try          <= r_try + 1'b1;
                        o_sccb_start   <= 1'b1;
                        o_sccb_rw      <= 1'b0;
                        o_sccb_addr    <= CHIP_ADDR & 8'hFE;
                        o_sccb_subaddr <= r_sub;
                        o_sccb_wdata   <= r_value;
                        r_state        <= S_WRITE;
                    end else begin
                        o_err_index <= r_index;
                        o_error     <= 1'b1;
                        o_busy      <= 1'b0;
                        r_state     <= S_FAIL;
                    end
                end
                // prescaler counts cycles within a ms, r_ms counts remaining ms
                S_DELAY: begin
                    if (r_pre == PW'(CYC_PER_MS - 1)) begin
                        r_pre <= '0;
                        if (r_ms == 8'd1) r_state <= S_NEXT;
                        else              r_ms    <= r_ms - 8'd1;
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_index    <= r_index + 1'b1;
                        o_rom_addr <= r_index + 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb/tb_sccb_init_seq.sv - directed and randomized bench for sccb_init_seq with an SCCB/ROM model
module tb_sccb_init_seq;
    logic clk = 1'b0;
    logic reset;
    logic clr;
    always #5 clk = ~clk;

    logic       start[2], sccb_start[2], rw[2], sdone[2], busy[2], done[2], error[2];
    logic [7:0] saddr[2], ssub[2], swd[2], srd[2], rom_addr[2], err_idx[2];
    logic [15:0] rom_q[2];
    logic [1:0] ra0, ei0;
    logic [3:0] ra1, ei1;
    assign rom_addr[0] = {6'd0, ra0};
    assign rom_addr[1] = {4'd0, ra1};
    assign err_idx[0]  = {6'd0, ei0};
    assign err_idx[1]  = {4'd0, ei1};

    sccb_init_seq #(.CHIP_ADDR(8'h42), .MAX_CMDS(4), .CYC_PER_MS(4), .VERIFY(1'b0), .MAX_TRIES(3)) u_nv (
        .clk(clk), .reset(reset), .i_start(start[0]), .o_rom_addr(ra0), .i_rom_data(rom_q[0]),
        .o_sccb_start(sccb_start[0]), .o_sccb_rw(rw[0]), .o_sccb_addr(saddr[0]),
        .o_sccb_subaddr(ssub[0]), .o_sccb_wdata(swd[0]), .i_sccb_rdata(srd[0]),
        .i_sccb_done(sdone[0]), .o_busy(busy[0]), .o_done(done[0]), .o_error(error[0]),
        .o_err_index(ei0));

    sccb_init_seq #(.CHIP_ADDR(8'h42), .MAX_CMDS(16), .CYC_PER_MS(4), .VERIFY(1'b1), .MAX_TRIES(3)) u_v (
        .clk(clk), .reset(reset), .i_start(start[1]), .o_rom_addr(ra1), .i_rom_data(rom_q[1]),
        .o_sccb_start(sccb_start[1]), .o_sccb_rw(rw[1]), .o_sccb_addr(saddr[1]),
        .o_sccb_subaddr(ssub[1]), .o_sccb_wdata(swd[1]), .i_sccb_rdata(srd[1]),
        .i_sccb_done(sdone[1]), .o_busy(busy[1]), .o_done(done[1]), .o_error(error[1]),
        .o_err_index(ei1));

    // ROM, camera register file and transaction log for both instances
    logic [15:0] rom[2][16];
    logic [7:0]  regs[2][256];
    logic [7:0]  bad_reg[2];
    int          bad_n[2];
    logic        pend[2], prw[2];
    logic [7:0]  psub[2], pwd[2];
    int          due[2], rdcnt[2], viol[2], logn[2];
    logic [63:0] logm[2][64];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rom_q[g] <= rom[g][rom_addr[g][3:0]];
            sdone[g] <= 1'b0;
            if (clr) begin
                logn[g]  <= 0;
                viol[g]  <= 0;
                rdcnt[g] <= 0;
                pend[g]  <= 1'b0;
            end else begin
                if (pend[g] && cyc == due[g] - 1) begin
                    sdone[g] <= 1'b1;
                    pend[g]  <= 1'b0;
                    if (!prw[g]) regs[g][psub[g]] <= pwd[g];
                    else if (psub[g] == bad_reg[g] && rdcnt[g] < bad_n[g]) begin
                        srd[g]   <= regs[g][psub[g]] ^ 8'h01;
                        rdcnt[g] <= rdcnt[g] + 1;
                    end else srd[g] <= regs[g][psub[g]];
                end
                if (sccb_start[g]) begin
                    if (pend[g]) viol[g] <= viol[g] + 1;
                    pend[g] <= 1'b1;
                    due[g]  <= cyc + 5;
                    prw[g]  <= rw[g];
                    psub[g] <= ssub[g];
                    pwd[g]  <= swd[g];
                    if (logn[g] < 64)
                        logm[g][logn[g]] <= {7'd0, rw[g], saddr[g], ssub[g], (rw[g] ? 8'h00 : swd[g]), cyc};
                    logn[g] <= logn[g] + 1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walks the table by the sequencing rules, timing each bus request
    // relative to the cycle start is sampled (3 cycles per entry overhead, 5-cycle ack).
    logic [63:0] expq[$];
    bit          e_done, e_err;
    int          e_idx;

    task automatic model(input int g, input bit ver, input int maxc);
        int  nx, left, s, tries;
        bit  fin, ok;
        logic [7:0] sb, vl;
        nx = 0; left = bad_n[g]; fin = 0;
        expq.delete(); e_done = 0; e_err = 0; e_idx = 0;
        for (int i = 0; i < maxc && !fin; i++) begin
            sb = rom[g][i][15:8];
            vl = rom[g][i][7:0];
            if (sb == 8'hFF) begin
                e_done = 1; fin = 1;
            end else if (sb == 8'hF0) begin
                nx = nx + 3 + int'(vl) * 4;
            end else begin
                tries = 0; ok = 0; s = nx + 3;
                while (!ok && !fin) begin
                    expq.push_back({7'd0, 1'b0, 8'h42, sb, vl, 32'(s)});
                    if (!ver || (sb == 8'h12 && vl[7])) begin
                        ok = 1; nx = s + 6;
                    end else begin
                        expq.push_back({7'd0, 1'b1, 8'h43, sb, 8'h00, 32'(s + 6)});
                        if (sb == bad_reg[g] && left > 0) begin
                            left--; tries++;
                            if (tries == 3) begin fin = 1; e_err = 1; e_idx = i; end
                            else s = s + 13;
                        end else begin
                            ok = 1; nx = s + 13;
                        end
                    end
                end
            end
            if (!fin && i == maxc - 1) e_done = 1;
        end
    endtask

    task automatic run(input int g, input int maxc, input bit ver, input bit poke, input string tag);
        int p, k, n;
        logic [63:0] act;
        model(g, ver, maxc);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        p = cyc; start[g] = 1'b1;
        @(negedge clk); start[g] = 1'b0;
        for (k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (k == 21) start[g] = 1'b0;
            if (done[g] || error[g]) break;
            if (poke && k == 20 && busy[g]) start[g] = 1'b1;
        end
        chk({tag, " finished"}, 64'(k < 6000), 64'd1);
        chk({tag, " txn count"}, 64'(logn[g]), 64'(expq.size()));
        n = (logn[g] < expq.size()) ? logn[g] : expq.size();
        for (int i = 0; i < n; i++) begin
            act = logm[g][i];
            act[31:0] = act[31:0] - 32'(p);
            chk($sformatf("%s txn%0d", tag, i), act, expq[i]);
        end
        chk({tag, " done"}, 64'(done[g]), 64'(e_done));
        chk({tag, " error"}, 64'(error[g]), 64'(e_err));
        if (e_err) chk({tag, " err_index"}, 64'(err_idx[g]), 64'(e_idx));
        chk({tag, " busy"}, 64'(busy[g]), 64'd0);
        chk({tag, " bus overlap"}, 64'(viol[g]), 64'd0);
    endtask

    initial begin
        int cnt, maxc, nent;
        reset = 1'b0; clr = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        bad_reg[0] = 8'hEE; bad_reg[1] = 8'hEE; bad_n[0] = 0; bad_n[1] = 0;
        for (int g = 0; g < 2; g++) for (int i = 0; i < 16; i++) rom[g][i] = 16'hFF00;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst busy%0d", g), 64'(busy[g]), 64'd0);
            chk($sformatf("rst done%0d", g), 64'(done[g] | error[g]), 64'd0);
            chk($sformatf("rst start%0d", g), 64'(sccb_start[g]), 64'd0);
            chk($sformatf("rst rom_addr%0d", g), 64'(rom_addr[g]), 64'd0);
            chk($sformatf("rst err_index%0d", g), 64'(err_idx[g]), 64'd0);
        end
        reset = 1'b1; clr = 1'b0;

        rom[0][0] = 16'h1280; rom[0][1] = 16'hF002; rom[0][2] = 16'h1100; rom[0][3] = 16'hFF5A;
        run(0, 4, 0, 0, "T1");

        rom[1][0] = 16'h1280; rom[1][1] = 16'hF001; rom[1][2] = 16'h1100; rom[1][3] = 16'hFF00;
        run(1, 16, 1, 0, "T2");
        bad_reg[1] = 8'h11; bad_n[1] = 255;
        run(1, 16, 1, 0, "T3");
        bad_n[1] = 1;
        run(1, 16, 1, 0, "T4");
        cnt = 0;
        for (int i = 0; i < logn[1]; i++)
            if (logm[1][i][56] == 1'b0 && logm[1][i][47:40] == 8'h11) cnt++;
        chk("T4 reg11 writes", 64'(cnt), 64'd2);
        bad_n[1] = 0;

        rom[1][0] = 16'h1155; rom[1][1] = 16'hF0FF; rom[1][2] = 16'hFF00;
        @(negedge clk); start[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0;
        repeat (40) @(negedge clk);
        chk("T5 in delay entry", 64'(rom_addr[1]), 64'd1);
        chk("T5 busy before", 64'(busy[1]), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("T5 busy after rst", 64'(busy[1]), 64'd0);
        chk("T5 start after rst", 64'(sccb_start[1]), 64'd0);
        chk("T5 rom_addr after rst", 64'(rom_addr[1]), 64'd0);
        reset = 1'b1;
        rom[1][0] = 16'h1A33; rom[1][1] = 16'hF000; rom[1][2] = 16'h1B44; rom[1][3] = 16'hFF00;
        run(1, 16, 1, 0, "T5");

        rom[0][0] = 16'h1101; rom[0][1] = 16'h1202; rom[0][2] = 16'h1303; rom[0][3] = 16'h1404;
        run(0, 4, 0, 1, "T6");

        for (int it = 0; it < 8; it++) begin
            int g;
            g = it % 2;
            maxc = g ? 16 : 4;
            nent = $urandom_range(1, maxc);
            for (int j = 0; j < 16; j++) begin
                case ($urandom_range(0, 9))
                    0, 1:    rom[g][j] = {8'hF0, 8'($urandom_range(0, 3))};
                    2:       rom[g][j] = {8'h12, 8'($urandom)};
                    default: rom[g][j] = {8'($urandom_range(0, 31)), 8'($urandom)};
                endcase
                if (j == nent && $urandom_range(0, 1) == 1) rom[g][j] = 16'hFF00;
            end
            bad_reg[g] = 8'($urandom_range(0, 31));
            bad_n[g]   = $urandom_range(0, 3);
            run(g, maxc, g == 1, it >= 6, $sformatf("R%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
